btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//  Conditions raw, bouncing board push-buttons before the input adapter and TTL models.
//  Per button: 2-flop synchroniser, then a stability counter, then a registered clean level.
//  Also emits 1-cycle press/release strobes.
//  Downstream logic uses btn_level[0] as the single-step clock source and btn_level[1] as
//  the clear source, in place of the raw button pins.
// PARAMETERS
//  N_BTN       2          number of independent button channels
//  CNT_W       20         stability counter width; must satisfy 2**CNT_W > DEB_CYCLES-1
//  DEB_CYCLES  1000000    cycles raw input must hold a new value before acceptance (>=2)
//  RAW_ACT_LOW 0          1: btn_raw pressed = 0 (inverted before sync); 0: pressed = 1
// PORTS
//  CLK          in   1      system clock; all state updates on posedge
//  CLR_n        in   1      asynchronous, active-low reset
//  btn_raw      in   N_BTN  raw asynchronous button pins
//  btn_level    out  N_BTN  debounced level, 1 = pressed; registered
//  btn_press    out  N_BTN  1-cycle strobe when btn_level goes 0->1; registered
//  btn_release  out  N_BTN  1-cycle strobe when btn_level goes 1->0; registered
// BEHAVIOUR
//  Reset (CLR_n=0, async): every internal register and output clears to 0.
//   - sync0, sync1, cnt, btn_level, btn_press, btn_release.
//   - Reset takes effect immediately and overrides any in-progress count.
//   - Release of reset is sampled at the next CLK edge; no strobe is generated by reset.
//  Polarity: p = btn_raw ^ {N_BTN{RAW_ACT_LOW}}. Pressed is always 1 internally.
//  Per channel i, every posedge:
//   - sync0 <= p[i]; sync1 <= sync0.
//   - if sync1 == btn_level[i]: cnt <= 0.
//   - elif cnt == DEB_CYCLES-1: btn_level[i] <= sync1; cnt <= 0.
//   - else: cnt <= cnt+1.
//   - btn_press[i]   <= (update this edge) & sync1.
//   - btn_release[i] <= (update this edge) & ~sync1.
//  Latency:
//   - Input p changes before edge k and then holds.
//   - btn_level and the strobe change at edge k+DEB_CYCLES+1 (DEB_CYCLES+2 edges incl. k).
//   - btn_press / btn_release are high for exactly one cycle, the same cycle btn_level changes.
//  Glitch rejection:
//   - Any return of sync1 to btn_level before the count completes resets cnt to 0.
//   - Pulses shorter than DEB_CYCLES cycles (after sync) never reach btn_level.
//  Channels are fully independent; simultaneous events on several channels update in parallel.
//  cnt never wraps: max value is DEB_CYCLES-1, then cleared.
//  Strobes on one channel are mutually exclusive; never both high in the same cycle.
// TESTING (bench uses DEB_CYCLES=4, N_BTN=2, RAW_ACT_LOW=0, CNT_W=3)
//  1 Reset:
//    - CLR_n=0 with btn_raw=2'b11 -> all outputs 0 within the same timestep, no CLK needed.
//    - Hold reset 3 clocks -> outputs stay 0.
//  2 Clean press:
//    - btn_raw[0] 0->1 before edge k, held -> btn_level[0]=1 from edge k+5.
//    - btn_press[0]=1 for only the cycle after edge k+5.
//  3 Bounce:
//    - btn_raw[0] toggles 1,0,1,0 every 2 cycles, then holds 1 -> exactly one btn_press[0].
//    - btn_level[0] rises 6 edges after the final 0->1.
//  4 Short glitch:
//    - btn_raw[1]=1 for 3 cycles then 0 -> btn_level[1] stays 0, no strobe.
//  5 Release + parallel:
//    - both held pressed, then btn_raw=2'b00 at one edge -> btn_level=2'b00 at edge +5.
//    - btn_release=2'b11 for one cycle; btn_press=2'b00 throughout.
//  6 Reset mid-count:
//    - press held, CLR_n pulsed low when cnt=2 -> btn_level stays 0 and cnt restarts.
//    - level rises 6 edges after CLR_n release; btn_press fires once.

Source files
------------

// File: rtl/btn_debounce_if.sv
// Button bundle between the board pins and the debouncer: raw pins in,
// clean level and 1-cycle press/release strobes out.
interface btn_debounce_if #(
  parameter int unsigned N_BTN = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel push-button conditioner: 2-flop synchroniser, stability counter,
// registered clean level, and registered 1-cycle press/release strobes.
module btn_debounce #(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter bit          RAW_ACT_LOW = 1'b0
) (
  input  logic          CLK,
  input  logic          CLR_n,
  btn_debounce_if.slave btn
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [N_BTN-1:0] w_p;
  logic [N_BTN-1:0] w_update;
  logic [N_BTN-1:0] r_sync0;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;
  logic [CNT_W-1:0] r_cnt [N_BTN];

  // Internally pressed is always 1, whatever the board wiring.
  assign w_p = btn.btn_raw ^ {N_BTN{RAW_ACT_LOW}};

  always_comb begin
    w_update = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      w_update[i] = (r_sync1[i] != r_level[i]) && (r_cnt[i] == LP_CNT_MAX);
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_sync0   <= '0;
      r_sync1   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync0   <= w_p;
      r_sync1   <= r_sync0;
      r_press   <= w_update & r_sync1;
      r_release <= w_update & ~r_sync1;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        // Any return to the accepted level restarts the stability window.
        if (r_sync1[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (w_update[i]) begin
          r_level[i] <= r_sync1[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn.btn_level   = r_level;
  assign btn.btn_press   = r_press;
  assign btn.btn_release = r_release;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEB_CYCLES=4: a per-cycle vector table
// plus hand-written async-reset sequences.
module tb_btn_debounce;

  typedef struct {
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;

  logic CLK;
  logic CLR_n;
  int   checks;
  int   failures;
  vec_t vecs[$];

  btn_debounce_if #(.N_BTN(2)) u_if ();

  btn_debounce #(
    .N_BTN      (2),
    .CNT_W      (3),
    .DEB_CYCLES (4),
    .RAW_ACT_LOW(1'b0)
  ) u_dut (
    .CLK  (CLK),
    .CLR_n(CLR_n),
    .btn  (u_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                         input logic [1:0] rel);
    chk({tag, " level"},   u_if.btn_level,   lvl);
    chk({tag, " press"},   u_if.btn_press,   prs);
    chk({tag, " release"}, u_if.btn_release, rel);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic [1:0] raw, input logic [1:0] lvl, input logic [1:0] prs,
                     input logic [1:0] rel, input int n);
    vec_t v;
    v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset: async clear with no clock edge, then held for 3 clocks.
    CLR_n = 1'b0;
    u_if.btn_raw = 2'b11;
    #1;
    chk_all("reset_async", 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("reset_hold", 2'b00, 2'b00, 2'b00);
    end
    CLR_n = 1'b1;
    u_if.btn_raw = 2'b00;

    // Idle
    add(2'b00, 2'b00, 2'b00, 2'b00, 2);
    // Clean press on ch0: level at edge k+5, one press strobe
    add(2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(2'b01, 2'b01, 2'b00, 2'b00, 2);
    // Release ch0
    add(2'b00, 2'b01, 2'b00, 2'b00, 5);
    add(2'b00, 2'b00, 2'b00, 2'b01, 1);
    add(2'b00, 2'b00, 2'b00, 2'b00, 1);
    // Bounce on ch0 (1,1,0,0,1,1,0,0) then hold 1: one press, 6 edges after final rise
    add(2'b01, 2'b00, 2'b00, 2'b00, 2);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2);
    add(2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(2'b01, 2'b01, 2'b00, 2'b00, 1);
    // Short glitch on ch1: 3 cycles high is one short of acceptance
    add(2'b11, 2'b01, 2'b00, 2'b00, 3);
    add(2'b01, 2'b01, 2'b00, 2'b00, 5);
    // Press ch1 while ch0 held
    add(2'b11, 2'b01, 2'b00, 2'b00, 5);
    add(2'b11, 2'b11, 2'b10, 2'b00, 1);
    add(2'b11, 2'b11, 2'b00, 2'b00, 1);
    // Parallel release
    add(2'b00, 2'b11, 2'b00, 2'b00, 5);
    add(2'b00, 2'b00, 2'b00, 2'b11, 1);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2);

    foreach (vecs[i]) begin
      u_if.btn_raw = vecs[i].raw;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel);
    end

    // Reset mid-count: press before edge k, counter reaches 2 after edge k+3
    u_if.btn_raw = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("midcnt_pre", 2'b00, 2'b00, 2'b00);
    end
    CLR_n = 1'b0;
    #1;
    chk_all("midcnt_clr", 2'b00, 2'b00, 2'b00);
    tick();
    chk_all("midcnt_hold", 2'b00, 2'b00, 2'b00);
    CLR_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 5)       chk_all($sformatf("midcnt_post%0d", k), 2'b00, 2'b00, 2'b00);
      else if (k == 5) chk_all("midcnt_rise", 2'b01, 2'b01, 2'b00);
      else             chk_all("midcnt_after", 2'b01, 2'b00, 2'b00);
    end

    // Async reset clears an accepted level immediately, without a clock
    #2;
    CLR_n = 1'b0;
    #1;
    chk_all("async_clear_level", 2'b00, 2'b00, 2'b00);
    tick();
    chk_all("async_clear_hold", 2'b00, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
